// File: rtl/regfile_pkg.sv
// Shared constants and busy-bit priority helpers for the register file scoreboard.
// Busy priority per register: flush > claim > write-clear > hold.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    BUSY_HOLD  = 2'd0,
    BUSY_CLR   = 2'd1,
    BUSY_SET   = 2'd2,
    BUSY_FLUSH = 2'd3
  } busy_op_e;

  function automatic busy_op_e resolve_busy_op(
    input logic flush,
    input logic claim_hit,
    input logic wr_hit
  );
    if (flush)          return BUSY_FLUSH;
    else if (claim_hit) return BUSY_SET;
    else if (wr_hit)    return BUSY_CLR;
    else                return BUSY_HOLD;
  endfunction

  function automatic logic apply_busy_op(input busy_op_e op, input logic cur);
    case (op)
      BUSY_SET:            return 1'b1;
      BUSY_CLR, BUSY_FLUSH: return 1'b0;
      default:             return cur;
    endcase
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy vector with claim/write-clear/flush priority and an
// incrementally maintained population count of busy registers.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic                 claim_ok;
  logic                 wr_ok;
  logic                 claim_inc;
  logic                 wr_dec;
  logic [DEPTH-1:0]     busy_next;
  logic [ADDR_W:0]      count_next;
  busy_op_e             op;

  assign claim_ok = claim_en && !(ZERO_REG && (claim_addr == '0));
  assign wr_ok    = wr_en    && !(ZERO_REG && (wr_addr    == '0));

  always_comb begin
    busy_next = busy;
    op        = BUSY_HOLD;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      op = resolve_busy_op(flush,
                           claim_ok && (claim_addr == ADDR_W'(i)),
                           wr_ok    && (wr_addr    == ADDR_W'(i)));
      busy_next[i] = apply_busy_op(op, busy[i]);
    end
  end

  // Count tracks the vector by delta: a claim only adds on a 0->1 transition,
  // a write only subtracts when it actually wins the clear on a busy register.
  always_comb begin
    claim_inc = claim_ok && !busy[claim_addr];
    wr_dec    = wr_ok && busy[wr_addr] && !(claim_ok && (claim_addr == wr_addr));
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = busy_count + {{ADDR_W{1'b0}}, claim_inc}
                              - {{ADDR_W{1'b0}}, wr_dec};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, one write port
// and an integrated busy scoreboard. Optional write-through forwarding: REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_busy_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // Returns {busy, data} for one read address; both ports share this path.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    logic              b;
    d = regs[addr];
    b = busy[addr];
    if (ZERO_REG && (addr == '0)) begin
      d = '0;
      b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_ok && (addr == wr_addr)) begin
      d = wr_data;
      b = claim_en && (claim_addr == wr_addr) && !flush;
    end
`endif
    return {b, d};
  endfunction

  always_comb begin
    {rd_busy1, rd_data1} = read_port(rd_addr1);
    {rd_busy2, rd_data2} = read_port(rd_addr2);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expectations, a monitor checks them.
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              rd_busy1, rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              flush;
  logic [ADDR_W:0]   busy_count;

  regfile_scoreboard #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_busy1   (rd_busy1),
    .rd_addr2   (rd_addr2),
    .rd_data2   (rd_data2),
    .rd_busy2   (rd_busy2),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DATA1, K_BUSY1, K_DATA2, K_BUSY2, K_COUNT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event kick;

  task automatic expect_val(input string n, input kind_e k, input logic [31:0] e);
    exp_t t;
    t.name = n;
    t.kind = k;
    t.exp  = e;
    sb.push_back(t);
  endtask

  // Hand the queued expectations to the monitor and wait (bounded) until consumed.
  task automatic check_now();
    -> kick;
    for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t        t;
    logic [31:0] act;
    forever begin
      @(kick);
      #1;
      while (sb.size() != 0) begin
        t = sb.pop_front();
        case (t.kind)
          K_DATA1: act = rd_data1;
          K_BUSY1: act = {31'b0, rd_busy1};
          K_DATA2: act = rd_data2;
          K_BUSY2: act = {31'b0, rd_busy2};
          default: act = {26'b0, busy_count};
        endcase
        checks++;
        if (act !== t.exp) begin
          errors++;
          $display("FAIL %s: actual=0x%08h required=0x%08h", t.name, act, t.exp);
        end
      end
    end
  end

  task automatic idle();
    wr_en    = 1'b0;
    claim_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd7;
    wr_addr = '0;
    wr_data = '0;
    claim_addr = '0;
    idle();
    #2;
    expect_val("reset_data", K_DATA1, 32'h0);
    expect_val("reset_busy", K_BUSY2, 32'h0);
    expect_val("reset_count", K_COUNT, 32'h0);
    check_now();
    #10 rst_n = 1'b1;

    // claim then write-clear of reg3
    claim_en = 1'b1; claim_addr = 5'd3;
    cyc(); idle();
    rd_addr1 = 5'd3;
    expect_val("claim3_busy", K_BUSY1, 32'h1);
    expect_val("claim3_count", K_COUNT, 32'h1);
    check_now();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
    cyc(); idle();
    expect_val("wr3_data", K_DATA1, 32'h0000_1234);
    expect_val("wr3_busy", K_BUSY1, 32'h0);
    expect_val("wr3_count", K_COUNT, 32'h0);
    check_now();

    // same-cycle claim and write of reg9: claim wins the busy bit
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
    claim_en = 1'b1; claim_addr = 5'd9;
    cyc(); idle();
    rd_addr2 = 5'd9;
    expect_val("cw9_data", K_DATA2, 32'hA5);
    expect_val("cw9_busy", K_BUSY2, 32'h1);
    expect_val("cw9_count", K_COUNT, 32'h1);
    check_now();

    // claim reg10 while writing busy reg9: count unchanged
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hB6;
    claim_en = 1'b1; claim_addr = 5'd10;
    cyc(); idle();
    rd_addr1 = 5'd10;
    expect_val("c10_busy", K_BUSY1, 32'h1);
    expect_val("w9_busy", K_BUSY2, 32'h0);
    expect_val("w9_data", K_DATA2, 32'hB6);
    expect_val("c10w9_count", K_COUNT, 32'h1);
    check_now();

    // re-claim busy reg10 and write non-busy reg11: count unchanged
    claim_en = 1'b1; claim_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h77;
    cyc(); idle();
    rd_addr2 = 5'd11;
    expect_val("reclaim_count", K_COUNT, 32'h1);
    expect_val("reclaim_busy", K_BUSY1, 32'h1);
    expect_val("w11_data", K_DATA2, 32'h77);
    check_now();

    // write reg12 with both ports reading it in the same cycle
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    rd_addr1 = 5'd12; rd_addr2 = 5'd12;
    expect_val("pre12_data1", K_DATA1, BYPASS ? 32'h55 : 32'h0);
    expect_val("pre12_data2", K_DATA2, BYPASS ? 32'h55 : 32'h0);
    check_now();
    cyc(); idle();
    expect_val("post12_data1", K_DATA1, 32'h55);
    expect_val("post12_data2", K_DATA2, 32'h55);
    check_now();

    // claim + write reg13 in one cycle: forwarded busy reflects the claim
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h1313;
    claim_en = 1'b1; claim_addr = 5'd13;
    rd_addr1 = 5'd13;
    expect_val("pre13_data", K_DATA1, BYPASS ? 32'h1313 : 32'h0);
    expect_val("pre13_busy", K_BUSY1, BYPASS ? 32'h1 : 32'h0);
    check_now();
    cyc(); idle();
    expect_val("post13_busy", K_BUSY1, 32'h1);
    expect_val("post13_count", K_COUNT, 32'h2);
    check_now();

    // claim every non-zero register
    for (int i = 1; i < 32; i++) begin
      claim_en = 1'b1; claim_addr = ADDR_W'(i);
      cyc(); idle();
    end
    rd_addr1 = 5'd31;
    expect_val("all_count", K_COUNT, 32'd31);
    expect_val("all_busy31", K_BUSY1, 32'h1);
    check_now();

    // flush discards the simultaneous claim
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd4;
    cyc(); idle();
    rd_addr1 = 5'd4;
    expect_val("flush_count", K_COUNT, 32'h0);
    expect_val("flush_busy4", K_BUSY1, 32'h0);
    check_now();

    // register 0 ignores write and claim
    claim_en = 1'b1; claim_addr = 5'd1;
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    claim_en = 1'b1; claim_addr = 5'd0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    cyc(); idle();
    expect_val("r0_data", K_DATA1, 32'h0);
    expect_val("r0_busy", K_BUSY2, 32'h0);
    expect_val("r0_count", K_COUNT, 32'h1);
    check_now();

    // asynchronous reset mid-run
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    claim_en = 1'b1; claim_addr = 5'd7;
    cyc(); idle();
    rd_addr1 = 5'd5; rd_addr2 = 5'd7;
    expect_val("pre_rst_data5", K_DATA1, 32'hDEAD_BEEF);
    expect_val("pre_rst_busy7", K_BUSY2, 32'h1);
    expect_val("pre_rst_count", K_COUNT, 32'h2);
    check_now();
    #2 rst_n = 1'b0;
    expect_val("rst_data5", K_DATA1, 32'h0);
    expect_val("rst_busy7", K_BUSY2, 32'h0);
    expect_val("rst_count", K_COUNT, 32'h0);
    check_now();
    @(negedge clk) rst_n = 1'b1;
    cyc();
    rd_addr2 = 5'd3;
    expect_val("post_rst_data5", K_DATA1, 32'h0);
    expect_val("post_rst_data3", K_DATA2, 32'h0);
    expect_val("post_rst_count", K_COUNT, 32'h0);
    check_now();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
